// File: rtl/dsa_mem_arbiter.sv
// Three-way arbiter for the single-port image memory: host (ext), write-back (wb), fetch (fe).
// Grants one access per cycle and steers read data back to the issuer via a tag pipeline.
module dsa_mem_arbiter #(
  parameter int ADDR_WIDTH   = 18,
  parameter int DATA_WIDTH   = 8,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ext_req,
  input  logic                  ext_we,
  input  logic [ADDR_WIDTH-1:0] ext_addr,
  input  logic [DATA_WIDTH-1:0] ext_wdata,
  output logic                  ext_gnt,
  output logic                  ext_rvalid,
  input  logic                  wb_req,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_wdata,
  output logic                  wb_gnt,
  input  logic                  fe_req,
  input  logic [ADDR_WIDTH-1:0] fe_addr,
  output logic                  fe_gnt,
  output logic                  fe_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_read_en,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic [15:0]           starve_events
);

  // Handshake: a requester holds req/addr/we/wdata until it sees gnt high in the
  // same cycle; the access is issued to memory in that cycle, req may drop before gnt.

  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_EXT  = 2'd1;
  localparam logic [1:0] TAG_FE   = 2'd2;
  localparam logic [7:0] LIMIT    = 8'(STARVE_LIMIT);

  logic [7:0] fe_wait;
  logic       promoted;
  logic [1:0] issue_tag;
  logic [1:0] ret_tag;
  logic [1:0] tag_q [RD_LATENCY];

  assign promoted = (fe_wait >= LIMIT);

  // Grants are gated by rst so nothing reaches memory while reset is held.
  assign ext_gnt = !rst && ext_req;
  assign fe_gnt  = !rst && !ext_req && fe_req && (promoted || !wb_req);
  assign wb_gnt  = !rst && !ext_req && wb_req && !(fe_req && promoted);

  always_comb begin
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    mem_addr     = '0;
    mem_data_in  = '0;
    issue_tag    = TAG_NONE;
    if (ext_gnt) begin
      mem_read_en  = !ext_we;
      mem_write_en = ext_we;
      mem_addr     = ext_addr;
      mem_data_in  = ext_wdata;
      issue_tag    = ext_we ? TAG_NONE : TAG_EXT;
    end else if (wb_gnt) begin
      mem_write_en = 1'b1;
      mem_addr     = wb_addr;
      mem_data_in  = wb_wdata;
    end else if (fe_gnt) begin
      mem_read_en  = 1'b1;
      mem_addr     = fe_addr;
      issue_tag    = TAG_FE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) tag_q[i] <= TAG_NONE;
      fe_wait       <= '0;
      starve_events <= '0;
    end else begin
      tag_q[0] <= issue_tag;
      for (int i = 1; i < RD_LATENCY; i++) tag_q[i] <= tag_q[i-1];
      if (!fe_req || fe_gnt) fe_wait <= '0;
      else if (fe_wait != 8'hFF) fe_wait <= fe_wait + 8'd1;
      if (fe_gnt && promoted && wb_req && starve_events != 16'hFFFF)
        starve_events <= starve_events + 16'd1;
    end
  end

  assign ret_tag    = tag_q[RD_LATENCY-1];
  assign ext_rvalid = (ret_tag == TAG_EXT);
  assign fe_rvalid  = (ret_tag == TAG_FE);
  assign rdata      = (ext_rvalid || fe_rvalid) ? mem_data_out : '0;

endmodule

// File: tb/tb_dsa_mem_arbiter.sv
// Directed bench: two arbiters (read latency 1 and 2) share stimulus, each with its own memory model.
module tb_dsa_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic ext_req, ext_we, wb_req, fe_req;
  logic [17:0] ext_addr, wb_addr, fe_addr;
  logic [7:0] ext_wdata, wb_wdata;

  logic ext_gnt_1, ext_rvalid_1, wb_gnt_1, fe_gnt_1, fe_rvalid_1, mem_read_en_1, mem_write_en_1;
  logic ext_gnt_2, ext_rvalid_2, wb_gnt_2, fe_gnt_2, fe_rvalid_2, mem_read_en_2, mem_write_en_2;
  logic [7:0] rdata_1, rdata_2, mem_data_in_1, mem_data_in_2, mem_data_out_1, mem_data_out_2;
  logic [17:0] mem_addr_1, mem_addr_2;
  logic [15:0] starve_1, starve_2;

  int checks = 0;
  int failures = 0;

  dsa_mem_arbiter #(.ADDR_WIDTH(18), .DATA_WIDTH(8), .RD_LATENCY(1), .STARVE_LIMIT(8)) u_dut1 (
    .clk(clk), .rst(rst),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt_1), .ext_rvalid(ext_rvalid_1),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_gnt(wb_gnt_1),
    .fe_req(fe_req), .fe_addr(fe_addr), .fe_gnt(fe_gnt_1), .fe_rvalid(fe_rvalid_1),
    .rdata(rdata_1), .mem_read_en(mem_read_en_1), .mem_write_en(mem_write_en_1),
    .mem_addr(mem_addr_1), .mem_data_in(mem_data_in_1), .mem_data_out(mem_data_out_1),
    .starve_events(starve_1)
  );

  dsa_mem_arbiter #(.ADDR_WIDTH(18), .DATA_WIDTH(8), .RD_LATENCY(2), .STARVE_LIMIT(8)) u_dut2 (
    .clk(clk), .rst(rst),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt_2), .ext_rvalid(ext_rvalid_2),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_gnt(wb_gnt_2),
    .fe_req(fe_req), .fe_addr(fe_addr), .fe_gnt(fe_gnt_2), .fe_rvalid(fe_rvalid_2),
    .rdata(rdata_2), .mem_read_en(mem_read_en_2), .mem_write_en(mem_write_en_2),
    .mem_addr(mem_addr_2), .mem_data_in(mem_data_in_2), .mem_data_out(mem_data_out_2),
    .starve_events(starve_2)
  );

  // Memory models; the read pipe returns 0xEE when no read was issued so rdata gating is visible.
  logic pl_en = 1'b0;
  logic [17:0] pl_addr = '0;
  logic [7:0] pl_data = '0;
  logic [7:0] mem1 [0:262143];
  logic [7:0] mem2 [0:262143];
  logic [7:0] p1, p2a, p2b;

  always @(posedge clk) begin
    p1  <= mem_read_en_1 ? mem1[mem_addr_1] : 8'hEE;
    p2a <= mem_read_en_2 ? mem2[mem_addr_2] : 8'hEE;
    p2b <= p2a;
    if (pl_en) begin
      mem1[pl_addr] <= pl_data;
      mem2[pl_addr] <= pl_data;
    end else begin
      if (mem_write_en_1) mem1[mem_addr_1] <= mem_data_in_1;
      if (mem_write_en_2) mem2[mem_addr_2] <= mem_data_in_2;
    end
  end
  assign mem_data_out_1 = p1;
  assign mem_data_out_2 = p2b;

  logic [56:0] all_1, all_2;
  logic [2:0]  gnt_1, gnt_2;
  logic [27:0] mv_1, mv_2;
  logic [9:0]  rv_1, rv_2;
  assign all_1 = {ext_gnt_1, ext_rvalid_1, wb_gnt_1, fe_gnt_1, fe_rvalid_1, rdata_1,
                  mem_read_en_1, mem_write_en_1, mem_addr_1, mem_data_in_1, starve_1};
  assign all_2 = {ext_gnt_2, ext_rvalid_2, wb_gnt_2, fe_gnt_2, fe_rvalid_2, rdata_2,
                  mem_read_en_2, mem_write_en_2, mem_addr_2, mem_data_in_2, starve_2};
  assign gnt_1 = {ext_gnt_1, wb_gnt_1, fe_gnt_1};
  assign gnt_2 = {ext_gnt_2, wb_gnt_2, fe_gnt_2};
  assign mv_1  = {mem_read_en_1, mem_write_en_1, mem_addr_1, mem_data_in_1};
  assign mv_2  = {mem_read_en_2, mem_write_en_2, mem_addr_2, mem_data_in_2};
  assign rv_1  = {ext_rvalid_1, fe_rvalid_1, rdata_1};
  assign rv_2  = {ext_rvalid_2, fe_rvalid_2, rdata_2};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pl(input logic [17:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    cyc();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 18'h00abc; ext_wdata = 8'h3c;
    wb_req = 1'b1; wb_addr = 18'h00def; wb_wdata = 8'h5c;
    fe_req = 1'b1; fe_addr = 18'h00123;
    cyc();
    pl(18'h00010, 8'h5a);
    pl(18'h00100, 8'h11);
    pl(18'h00101, 8'h12);
    pl(18'h00102, 8'h13);
    pl(18'h00103, 8'h14);
    #4;
    if (all_1 !== 57'd0) begin failures++; $display("FAIL reset_hold_d1 got=%h exp=0", all_1); end
    checks++;
    if (all_2 !== 57'd0) begin failures++; $display("FAIL reset_hold_d2 got=%h exp=0", all_2); end
    checks++;
    ext_req = 1'b0; wb_req = 1'b0; fe_req = 1'b0;
    ext_addr = '0; wb_addr = '0; fe_addr = '0; ext_wdata = '0; wb_wdata = '0;
    cyc();
    rst = 1'b0;
    #4;
    if (all_1 !== 57'd0) begin failures++; $display("FAIL idle_d1 got=%h exp=0", all_1); end
    checks++;
    if (all_2 !== 57'd0) begin failures++; $display("FAIL idle_d2 got=%h exp=0", all_2); end
    checks++;
  endtask

  task automatic test_ext_read();
    cyc();
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 18'h00010; ext_wdata = 8'h00;
    #4;
    if (gnt_1 !== 3'b100) begin failures++; $display("FAIL ext_rd_gnt got=%b exp=100", gnt_1); end
    checks++;
    if (mv_1 !== {1'b1, 1'b0, 18'h00010, 8'h00}) begin
      failures++; $display("FAIL ext_rd_mem got=%h exp=%h", mv_1, {1'b1, 1'b0, 18'h00010, 8'h00});
    end
    checks++;
    cyc();
    ext_req = 1'b0;
    #4;
    if (rv_1 !== {2'b10, 8'h5a}) begin failures++; $display("FAIL ext_rd_ret1_d1 got=%h exp=%h", rv_1, {2'b10, 8'h5a}); end
    checks++;
    if (rv_2 !== 10'd0) begin failures++; $display("FAIL ext_rd_ret1_d2 got=%h exp=0", rv_2); end
    checks++;
    cyc();
    #4;
    if (rv_1 !== 10'd0) begin failures++; $display("FAIL ext_rd_ret2_d1 got=%h exp=0", rv_1); end
    checks++;
    if (rv_2 !== {2'b10, 8'h5a}) begin failures++; $display("FAIL ext_rd_ret2_d2 got=%h exp=%h", rv_2, {2'b10, 8'h5a}); end
    checks++;
    cyc();
    #4;
    if ({rv_1, rv_2} !== 20'd0) begin failures++; $display("FAIL ext_rd_ret3 got=%h exp=0", {rv_1, rv_2}); end
    checks++;
  endtask

  task automatic test_priority();
    cyc();
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 18'h00001; ext_wdata = 8'h00;
    wb_req = 1'b1; wb_addr = 18'h00002; wb_wdata = 8'ha5;
    fe_req = 1'b1; fe_addr = 18'h00003;
    #4;
    if ({gnt_1, gnt_2} !== 6'b100100) begin failures++; $display("FAIL prio_ext got=%b exp=100100", {gnt_1, gnt_2}); end
    checks++;
    if (mv_1 !== {1'b1, 1'b0, 18'h00001, 8'h00}) begin failures++; $display("FAIL prio_ext_mem got=%h", mv_1); end
    checks++;
    cyc();
    ext_req = 1'b0;
    #4;
    if ({gnt_1, gnt_2} !== 6'b010010) begin failures++; $display("FAIL prio_wb got=%b exp=010010", {gnt_1, gnt_2}); end
    checks++;
    if (mv_1 !== {1'b0, 1'b1, 18'h00002, 8'ha5}) begin
      failures++; $display("FAIL prio_wb_mem got=%h exp=%h", mv_1, {1'b0, 1'b1, 18'h00002, 8'ha5});
    end
    checks++;
    cyc();
    wb_req = 1'b0;
    #4;
    if ({gnt_1, gnt_2} !== 6'b001001) begin failures++; $display("FAIL prio_fe got=%b exp=001001", {gnt_1, gnt_2}); end
    checks++;
    if (mv_2 !== {1'b1, 1'b0, 18'h00003, 8'h00}) begin failures++; $display("FAIL prio_fe_mem got=%h", mv_2); end
    checks++;
    cyc();
    fe_req = 1'b0;
    #4;
    if ({gnt_1, gnt_2, mv_1} !== 34'd0) begin failures++; $display("FAIL prio_idle got=%h exp=0", {gnt_1, gnt_2, mv_1}); end
    checks++;
    cyc();
    cyc();
  endtask

  task automatic test_starve();
    logic [2:0] exp_g;
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (c == 0) begin
        wb_req = 1'b1; wb_addr = 18'h03000; wb_wdata = 8'h00;
        fe_req = 1'b1; fe_addr = 18'h04000;
      end
      #4;
      exp_g = (c == 8) ? 3'b001 : 3'b010;
      if (gnt_1 !== exp_g || gnt_2 !== exp_g) begin
        failures++; $display("FAIL starve_gnt c=%0d got=%b/%b exp=%b", c, gnt_1, gnt_2, exp_g);
      end
      checks++;
      if (c == 0 && {starve_1, starve_2} !== 32'd0) begin
        failures++; $display("FAIL starve_cnt0 got=%h exp=0", {starve_1, starve_2});
      end
      if (c == 0) checks++;
    end
    if (starve_1 !== 16'd1 || starve_2 !== 16'd1) begin
      failures++; $display("FAIL starve_cnt1 got=%h/%h exp=1", starve_1, starve_2);
    end
    checks++;
    cyc();
    wb_req = 1'b0; fe_req = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic test_back_to_back();
    logic v1, v2;
    logic [7:0] d1, d2;
    for (int c = 0; c < 8; c++) begin
      cyc();
      if (c < 4) begin fe_req = 1'b1; fe_addr = 18'h00100 + 18'(c); end
      else fe_req = 1'b0;
      #4;
      if (c < 4 && gnt_2 !== 3'b001) begin failures++; $display("FAIL b2b_gnt c=%0d got=%b exp=001", c, gnt_2); end
      if (c < 4) checks++;
      v1 = (c >= 1 && c <= 4);
      v2 = (c >= 2 && c <= 5);
      d1 = v1 ? 8'h11 + 8'(c - 1) : 8'h00;
      d2 = v2 ? 8'h11 + 8'(c - 2) : 8'h00;
      if (rv_1 !== {1'b0, v1, d1}) begin failures++; $display("FAIL b2b_ret_d1 c=%0d got=%h exp=%h", c, rv_1, {1'b0, v1, d1}); end
      checks++;
      if (rv_2 !== {1'b0, v2, d2}) begin failures++; $display("FAIL b2b_ret_d2 c=%0d got=%h exp=%h", c, rv_2, {1'b0, v2, d2}); end
      checks++;
    end
  endtask

  task automatic test_reset_mid();
    cyc();
    fe_req = 1'b1; fe_addr = 18'h00102;
    #4;
    if (gnt_2 !== 3'b001) begin failures++; $display("FAIL rstmid_gnt got=%b exp=001", gnt_2); end
    checks++;
    for (int c = 1; c <= 5; c++) begin
      cyc();
      if (c == 1) begin fe_req = 1'b0; rst = 1'b1; end
      if (c == 3) rst = 1'b0;
      #4;
      if (rv_2 !== 10'd0) begin failures++; $display("FAIL rstmid_no_ret c=%0d got=%h exp=0", c, rv_2); end
      checks++;
    end
    if ({starve_1, starve_2} !== 32'd0) begin
      failures++; $display("FAIL rstmid_starve got=%h exp=0", {starve_1, starve_2});
    end
    checks++;
    cyc();
    fe_req = 1'b1; fe_addr = 18'h00101;
    #4;
    if (gnt_2 !== 3'b001) begin failures++; $display("FAIL rstmid_new_gnt got=%b exp=001", gnt_2); end
    checks++;
    cyc();
    fe_req = 1'b0;
    #4;
    if (rv_1 !== {2'b01, 8'h12}) begin failures++; $display("FAIL rstmid_new_d1 got=%h exp=%h", rv_1, {2'b01, 8'h12}); end
    checks++;
    cyc();
    #4;
    if (rv_2 !== {2'b01, 8'h12}) begin failures++; $display("FAIL rstmid_new_d2 got=%h exp=%h", rv_2, {2'b01, 8'h12}); end
    checks++;
  endtask

  task automatic test_write_read();
    cyc();
    wb_req = 1'b1; wb_addr = 18'h20000; wb_wdata = 8'h77;
    #4;
    if (gnt_1 !== 3'b010) begin failures++; $display("FAIL wr_gnt got=%b exp=010", gnt_1); end
    checks++;
    if (mv_1 !== {1'b0, 1'b1, 18'h20000, 8'h77} || mv_2 !== mv_1) begin
      failures++; $display("FAIL wr_mem got=%h/%h exp=%h", mv_1, mv_2, {1'b0, 1'b1, 18'h20000, 8'h77});
    end
    checks++;
    cyc();
    wb_req = 1'b0;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 18'h20000; ext_wdata = 8'h00;
    #4;
    if (gnt_2 !== 3'b100) begin failures++; $display("FAIL wr_rd_gnt got=%b exp=100", gnt_2); end
    checks++;
    cyc();
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 18'h20001; ext_wdata = 8'h33;
    #4;
    if (rv_1 !== {2'b10, 8'h77}) begin failures++; $display("FAIL wr_rd_ret_d1 got=%h exp=%h", rv_1, {2'b10, 8'h77}); end
    checks++;
    if (mv_1 !== {1'b0, 1'b1, 18'h20001, 8'h33}) begin failures++; $display("FAIL ext_wr_mem got=%h", mv_1); end
    checks++;
    cyc();
    ext_req = 1'b0; ext_we = 1'b0;
    #4;
    if (rv_2 !== {2'b10, 8'h77}) begin failures++; $display("FAIL wr_rd_ret_d2 got=%h exp=%h", rv_2, {2'b10, 8'h77}); end
    checks++;
    if (rv_1 !== 10'd0) begin failures++; $display("FAIL ext_wr_noret_d1 got=%h exp=0", rv_1); end
    checks++;
    cyc();
    #4;
    if (rv_2 !== 10'd0) begin failures++; $display("FAIL ext_wr_noret_d2 got=%h exp=0", rv_2); end
    checks++;
  endtask

  initial begin
    test_reset();
    test_ext_read();
    test_priority();
    test_starve();
    test_back_to_back();
    test_reset_mid();
    test_write_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dsa_mem_arbiter.md
Name: dsa_mem_arbiter

Overview:
- Arbitrates the single-port 8-bit image memory between three requesters: external host port (ext), interpolation write-back (wb), and pixel fetch unit (fe).
- Grants exactly one access per cycle and routes read data back to the issuing requester with a per-requester valid strobe.
- An anti-starvation counter guarantees fetch progress under sustained write-back traffic.
- Sits between the control FSMs/fetch unit and the memory interface instance in the DSA top level.

Parameters:
- ADDR_WIDTH, 18, memory address width
- DATA_WIDTH, 8, memory data width
- RD_LATENCY, 1, cycles from granted read to valid mem_data_out (1..4)
- STARVE_LIMIT, 8, consecutive denied fe cycles before fe is promoted above wb (2..255)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- ext_req  in  1  host access request
- ext_we  in  1  1 = write, 0 = read
- ext_addr  in  ADDR_WIDTH  host address
- ext_wdata  in  DATA_WIDTH  host write data
- ext_gnt  out  1  host access accepted this cycle
- ext_rvalid  out  1  host read data valid on rdata
- wb_req  in  1  write-back request (write only)
- wb_addr  in  ADDR_WIDTH  write-back address
- wb_wdata  in  DATA_WIDTH  write-back data
- wb_gnt  out  1  write-back accepted
- fe_req  in  1  fetch read request
- fe_addr  in  ADDR_WIDTH  fetch address
- fe_gnt  out  1  fetch accepted
- fe_rvalid  out  1  fetch read data valid on rdata
- rdata  out  DATA_WIDTH  read data, shared by all requesters
- mem_read_en  out  1  to memory
- mem_write_en  out  1  to memory
- mem_addr  out  ADDR_WIDTH  to memory
- mem_data_in  out  DATA_WIDTH  to memory
- mem_data_out  in  DATA_WIDTH  from memory
- starve_events  out  16  saturating count of fe promotions

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
  - While rst is high: all gnt, rvalid, mem_read_en and mem_write_en are 0; mem_addr and mem_data_in are 0.
  - Reset clears the tag pipeline, fe_wait and starve_events.
- Request protocol: req, addr, we and wdata are held stable until gnt is sampled high. gnt is combinational in the same cycle as the request; the access is issued to memory in that cycle. A requester may drop req before grant (withdraw) without penalty.
- At most one gnt is high per cycle. Memory outputs reflect the granted requester; all memory outputs are 0 when no request is granted.
- Priority:
  - ext always highest.
  - Otherwise, if fe is promoted, fe beats wb.
  - Otherwise wb beats fe.
- Starvation:
  - 8-bit fe_wait increments on each cycle with fe_req=1 and fe_gnt=0. It clears on fe_gnt or when fe_req=0.
  - Promoted is true when fe_wait >= STARVE_LIMIT.
  - A grant to fe while promoted and wb_req=1 increments starve_events, saturating at 16'hFFFF.
  - fe_wait never wraps; it saturates at 255.
- Read return:
  - A RD_LATENCY-deep shift register carries a 2-bit tag (none/ext/fe) per granted read.
  - RD_LATENCY cycles after the grant, the matching rvalid pulses for 1 cycle with rdata = mem_data_out.
  - rdata is 0 when no rvalid is asserted.
  - Back-to-back reads pipeline fully, one return per cycle.
- Writes produce no response; the write completes in the grant cycle.
- Simultaneous events: a read returning in the same cycle a new access is granted is legal; return and issue are independent.
- Reset mid-operation: in-flight read tags are discarded; no rvalid is asserted after rst deasserts for reads issued before reset.

Test Plan:
- Reset, then idle → all outputs 0. ext read of addr 0x00010 (memory holds 0x5A), RD_LATENCY=1 → ext_gnt in cycle 0; ext_rvalid=1 with rdata=0x5A in cycle 1, for one cycle only.
- ext, wb and fe all requesting in the same cycle → ext_gnt only. Next cycle, with ext dropped → wb_gnt. Cycle after, with wb dropped → fe_gnt. No cycle has two grants.
- wb_req held continuously and fe_req held from cycle 0, STARVE_LIMIT=8 → wb granted in cycles 0–7. fe_gnt in cycle 8 and starve_events=1; wb granted again in cycle 9.
- fe reads of addresses 0x100..0x103 back-to-back, RD_LATENCY=2, memory holding 0x11..0x14 → fe_rvalid high in cycles 2–5 with rdata 0x11, 0x12, 0x13, 0x14 in order; ext_rvalid stays 0 throughout.
- fe read granted, then rst asserted in the following cycle (RD_LATENCY=2) → fe_rvalid is never asserted. After release, fe_wait=0, starve_events=0 and a new read returns normally.
- wb write of 0x77 to 0x20000, then ext read of 0x20000 → mem_write_en with mem_data_in=0x77 in the grant cycle; the later ext read returns 0x77.
